// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: show-ahead FIFO between the instruction source and
// decode. Each accepted instruction is tagged with its fetch PC. A flush
// empties the queue and reloads the fetch PC for a redirect.
module instr_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [31:0]              instr_in,
   input  logic                     instr_valid,
   output logic                     instr_ready,
   output logic [31:0]              instr_out,
   output logic [31:0]              pc_out,
   output logic                     out_valid,
   input  logic                     out_ready,
   input  logic                     flush,
   input  logic [31:0]              flush_pc,
   output logic [$clog2(DEPTH):0]   count,
   output logic [31:0]              fetch_pc
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   entry_t        mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          enq;
   logic          deq;

   // Ready is held low during reset and flush; no full-bypass, so a full
   // queue refuses input even when the head leaves in the same cycle.
   assign instr_ready = !reset && !flush && (count < FULL);
   assign out_valid   = (count != '0);
   assign enq         = instr_valid && instr_ready;
   assign deq         = out_valid && out_ready && !flush;

   // Show-ahead head: the read-pointer entry is visible without latency.
   assign instr_out = out_valid ? mem[rd_ptr].instr : NOP;
   assign pc_out    = out_valid ? mem[rd_ptr].pc    : 32'h0;

   // Storage write; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (enq)
         mem[wr_ptr] <= {instr_in, fetch_pc};
   end

   // Pointers, occupancy and fetch PC; flush outranks enqueue and dequeue.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         fetch_pc <= RESET_PC;
      end else if (flush) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         fetch_pc <= flush_pc;
      end else begin
         if (enq) begin
            wr_ptr   <= wr_ptr + PW'(1);
            fetch_pc <= fetch_pc + 32'd4;
         end
         if (deq)
            rd_ptr <= rd_ptr + PW'(1);
         case ({enq, deq})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: queue-based reference model,
// per-cycle compare on the falling edge, directed scenarios with literal
// expectations, then randomized traffic with flushes and reset pulses.
module tb_instr_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr_in;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic        out_valid;
   logic        out_ready;
   logic        flush;
   logic [31:0] flush_pc;
   logic [$clog2(DEPTH):0] count;
   logic [31:0] fetch_pc;

   always #5 clk = ~clk;

   instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP(NOP)) dut (
      .clk(clk), .reset(reset),
      .instr_in(instr_in), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_out(instr_out), .pc_out(pc_out), .out_valid(out_valid),
      .out_ready(out_ready), .flush(flush), .flush_pc(flush_pc),
      .count(count), .fetch_pc(fetch_pc)
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] mpc = RESET_PC;
   bit          m_e, m_d;
   int          nchk = 0;
   int          nerr = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Reference model: a plain queue of {instr, pc} plus a running fetch PC.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mq.delete();
         mpc = RESET_PC;
      end else if (flush) begin
         mq.delete();
         mpc = flush_pc;
      end else begin
         m_e = instr_valid && (mq.size() < DEPTH);
         m_d = out_ready && (mq.size() != 0);
         if (m_d) void'(mq.pop_front());
         if (m_e) begin
            mq.push_back('{instr_in, mpc});
            mpc = mpc + 32'd4;
         end
      end
   end

   // Compare every output against the model away from the active edge.
   always @(negedge clk) begin
      chk("count",       32'(count),       32'(mq.size()));
      chk("out_valid",   32'(out_valid),   32'(mq.size() != 0));
      chk("instr_ready", 32'(instr_ready), 32'(!reset && !flush && mq.size() < DEPTH));
      chk("instr_out",   instr_out,        (mq.size() != 0) ? mq[0].instr : NOP);
      chk("pc_out",      pc_out,           (mq.size() != 0) ? mq[0].pc : 32'h0);
      chk("fetch_pc",    fetch_pc,         mpc);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; instr_in = '0; instr_valid = 1'b0; out_ready = 1'b0;
      flush = 1'b0; flush_pc = '0;
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_count",    32'(count),       32'd0);
      chk("rst_valid",    32'(out_valid),   32'd0);
      chk("rst_ready",    32'(instr_ready), 32'd0);
      chk("rst_instr",    instr_out,        NOP);
      chk("rst_pc",       pc_out,           32'h0);
      chk("rst_fetch_pc", fetch_pc,         RESET_PC);
      reset = 1'b0;

      // Single enqueue with decode stalled: visible the next cycle.
      instr_valid = 1'b1; instr_in = 32'h2008_0005;
      step();
      instr_valid = 1'b0;
      chk("t1_valid",    32'(out_valid), 32'd1);
      chk("t1_instr",    instr_out,      32'h2008_0005);
      chk("t1_pc",       pc_out,         32'h0);
      chk("t1_count",    32'(count),     32'd1);
      chk("t1_fetch_pc", fetch_pc,       32'd4);

      // Five back-to-back enqueues into a 4-deep queue.
      flush = 1'b1; flush_pc = 32'h0;
      step();
      flush = 1'b0;
      instr_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         instr_in = 32'h100 + 32'(i);
         step();
      end
      instr_in = 32'h104;
      #1;
      chk("t2_ready_full", 32'(instr_ready), 32'd0);
      chk("t2_count_full", 32'(count),       32'd4);
      chk("t2_fetch_pc",   fetch_pc,         32'd16);
      step();
      chk("t2_count_hold", 32'(count), 32'd4);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t2_count_deq", 32'(count), 32'd3);
      step();
      instr_valid = 1'b0;
      chk("t2_count_5th", 32'(count), 32'd4);
      chk("t2_head_instr", instr_out, 32'h101);
      chk("t2_head_pc",    pc_out,    32'd4);

      // Steady stream at occupancy 3 across pointer wrap.
      flush = 1'b1; flush_pc = 32'h0;
      step();
      flush = 1'b0;
      for (int k = 0; k < 3; k++) begin
         instr_valid = 1'b1; instr_in = 32'h200 + 32'(k);
         step();
      end
      for (int j = 0; j < 10; j++) begin
         chk("t3_count", 32'(count), 32'd3);
         chk("t3_instr", instr_out,  32'h200 + 32'(j));
         chk("t3_pc",    pc_out,     32'(4 * j));
         instr_in = 32'h203 + 32'(j); out_ready = 1'b1;
         step();
      end

      // Flush with traffic present on both sides.
      flush = 1'b1; flush_pc = 32'h0000_0400; instr_valid = 1'b1;
      instr_in = 32'hDEAD_BEEF; out_ready = 1'b1;
      #1;
      chk("t4_ready_flush", 32'(instr_ready), 32'd0);
      step();
      flush = 1'b0; instr_valid = 1'b0; out_ready = 1'b0;
      chk("t4_count",    32'(count),     32'd0);
      chk("t4_valid",    32'(out_valid), 32'd0);
      chk("t4_instr",    instr_out,      NOP);
      chk("t4_fetch_pc", fetch_pc,       32'h400);
      instr_valid = 1'b1; instr_in = 32'h300;
      step();
      instr_valid = 1'b0;
      chk("t4_pc",     pc_out,    32'h400);
      chk("t4_instr2", instr_out, 32'h300);

      // Fetch PC wraps past the top of the address space.
      flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
      step();
      flush = 1'b0; instr_valid = 1'b1; instr_in = 32'h500;
      step();
      instr_in = 32'h501;
      step();
      instr_valid = 1'b0;
      chk("t5_count", 32'(count), 32'd2);
      chk("t5_pc0",   pc_out,     32'hFFFF_FFFC);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t5_pc1",       pc_out,    32'h0);
      chk("t5_instr1",    instr_out, 32'h501);
      chk("t5_fetch_pc",  fetch_pc,  32'd4);

      // Asynchronous reset mid-cycle with two entries queued.
      flush = 1'b1; flush_pc = 32'h0000_0080;
      step();
      flush = 1'b0; instr_valid = 1'b1; instr_in = 32'h600;
      step();
      instr_in = 32'h601;
      step();
      instr_valid = 1'b0;
      chk("t6_count_pre", 32'(count), 32'd2);
      #2 reset = 1'b1;
      #1;
      chk("t6_count",    32'(count),       32'd0);
      chk("t6_valid",    32'(out_valid),   32'd0);
      chk("t6_fetch_pc", fetch_pc,         RESET_PC);
      chk("t6_ready",    32'(instr_ready), 32'd0);
      step();
      reset = 1'b0;

      // Randomized traffic with occasional flushes and reset pulses.
      for (int n = 0; n < 2000; n++) begin
         instr_valid = ($urandom_range(0, 3) != 0);
         instr_in    = $urandom();
         out_ready   = ($urandom_range(0, 2) != 0);
         flush       = ($urandom_range(0, 19) == 0);
         flush_pc    = $urandom();
         if ($urandom_range(0, 299) == 0) begin
            #1 reset = 1'b1;
            #1 reset = 1'b0;
         end
         step();
      end

      instr_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      repeat (3) step();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
